pktbuf_rd_arbiter: RTL and testbench

PKTBUF_RD_ARBITER -- requirements
Module: pktbuf_rd_arbiter

---
 rtl/pktbuf_rd_arbiter_pkg.sv | 24 ++
 rtl/pktbuf_rd_arbiter_tag_fifo.sv | 55 +++++
 rtl/pktbuf_rd_arbiter.sv | 118 +++++++++++
 tb/tb_pktbuf_rd_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pktbuf_rd_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | pktbuf_rd_arbiter_pkg : shared packet-buffer types, arbiter states |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package pktbuf_rd_arbiter_pkg;

  localparam int PKTBUF_AWIDTH = 12;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } flit_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/pktbuf_rd_arbiter_tag_fifo.sv
// +--------------------------------------------------------------------+
// | arb_tag_fifo : show-ahead 1-bit FIFO holding read owner tags       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module arb_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Caller guarantees push only when not full (or popping) and pop only when not empty.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/pktbuf_rd_arbiter.sv
// +--------------------------------------------------------------------+
// | pktbuf_rd_arbiter : 2-way packet-buffer read arbiter with bursts   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pktbuf_rd_arbiter
  import pktbuf_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [PKTBUF_AWIDTH-1:0] rd_addr       [0:1],
  input  logic                     rd_req        [0:1],
  input  logic                     rd_lock       [0:1],
  output logic                     rd_gnt        [0:1],
  output logic                     rd_valid      [0:1],
  output flit_t                    rd_data       [0:1],
  output logic [PKTBUF_AWIDTH-1:0] mem_address,
  output logic                     mem_read,
  input  logic                     mem_readvalid,
  input  flit_t                    mem_readdata,
  output logic [31:0]              stats_gnt     [0:1],
  output logic                     err_orphan
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_winner, last_winner_nxt;
  logic       win;
  logic [1:0] gnt;
  logic       accept;
  logic       pop;
  logic       issue_ok;
  logic       fifo_head, fifo_empty, fifo_full;

  // A return in the same cycle frees a slot, so a full FIFO may still accept.
  assign pop      = Rst_n & mem_readvalid & ~fifo_empty;
  assign issue_ok = Rst_n & (~fifo_full | pop);

  always_comb begin
    gnt             = 2'b00;
    win             = 1'b0;
    state_nxt       = state;
    owner_nxt       = owner;
    last_winner_nxt = last_winner;

    if (state == ARB_LOCKED)          win = owner;
    else if (rd_req[0] & rd_req[1])   win = ~last_winner;
    else                              win = rd_req[1];

    gnt[win] = rd_req[win] & issue_ok;

    if (gnt != 2'b00) begin
      if (rd_lock[win]) begin
        state_nxt = ARB_LOCKED;
        owner_nxt = win;
      end else begin
        state_nxt       = ARB_IDLE;
        last_winner_nxt = win;
      end
    end else if (state == ARB_LOCKED && !rd_req[owner] && !rd_lock[owner]) begin
      state_nxt = ARB_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state       <= ARB_IDLE;
      owner       <= 1'b0;
      last_winner <= 1'b1;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_winner <= last_winner_nxt;
    end
  end

  assign accept      = (gnt != 2'b00);
  assign mem_read    = accept;
  assign mem_address = accept ? rd_addr[win] : '0;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (accept),
    .push_data (win),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n)                           err_orphan <= 1'b0;
    else if (mem_readvalid && fifo_empty) err_orphan <= 1'b1;
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    logic [31:0] cnt;

    assign rd_gnt[i]    = gnt[i];
    assign rd_valid[i]  = pop & (fifo_head == 1'(i));
    assign rd_data[i]   = rd_valid[i] ? mem_readdata : '0;
    assign stats_gnt[i] = cnt;

    always_ff @(posedge Clk) begin
      if (!Rst_n)      cnt <= '0;
      else if (gnt[i]) cnt <= cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pktbuf_rd_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_pktbuf_rd_arbiter : scoreboard bench with in-order memory model |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pktbuf_rd_arbiter;
  import pktbuf_rd_arbiter_pkg::*;

  localparam int MAX_OUTST = 16;
  localparam int LAT       = 3;

  logic                     Clk = 1'b0;
  logic                     Rst_n = 1'b0;
  logic [PKTBUF_AWIDTH-1:0] rd_addr  [0:1];
  logic                     rd_req   [0:1];
  logic                     rd_lock  [0:1];
  logic                     rd_gnt   [0:1];
  logic                     rd_valid [0:1];
  flit_t                    rd_data  [0:1];
  logic [PKTBUF_AWIDTH-1:0] mem_address;
  logic                     mem_read;
  logic                     mem_readvalid;
  flit_t                    mem_readdata;
  logic [31:0]              stats_gnt [0:1];
  logic                     err_orphan;

  pktbuf_rd_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .rd_addr       (rd_addr),
    .rd_req        (rd_req),
    .rd_lock       (rd_lock),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .mem_readvalid (mem_readvalid),
    .mem_readdata  (mem_readdata),
    .stats_gnt     (stats_gnt),
    .err_orphan    (err_orphan)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [PKTBUF_AWIDTH-1:0] addr; int due; } mem_ent_t;
  typedef struct { logic who; flit_t data; } exp_ent_t;

  mem_ent_t   mem_q[$];
  exp_ent_t   exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic       mem_stall = 1'b0;
  logic       allow_one = 1'b0;
  logic       inject_orphan = 1'b0;
  logic       chk_gnt = 1'b0;
  logic       exp_orphan = 1'b0;
  logic [1:0] exp_gnt = 2'b00;

  function automatic flit_t mk_flit(input logic [PKTBUF_AWIDTH-1:0] a);
    flit_t f;
    f.sop  = a[0];
    f.eop  = a[1];
    f.data = {4'hA, a, 4'h5, ~a};
    return f;
  endfunction

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive memory return, observe at negedge, update the model.
  task automatic cycle();
    logic       rv;
    logic       had_out;
    logic [1:0] g;
    logic [1:0] v;
    rv = 1'b0;
    if (inject_orphan) begin
      rv            = 1'b1;
      mem_readdata  = '1;
      inject_orphan = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc && (!mem_stall || allow_one)) begin
      rv           = 1'b1;
      mem_readdata = mk_flit(mem_q[0].addr);
      void'(mem_q.pop_front());
      allow_one    = 1'b0;
    end
    mem_readvalid = rv;
    @(negedge Clk);
    g = {rd_gnt[1], rd_gnt[0]};
    v = {rd_valid[1], rd_valid[0]};
    check_value("err_orphan", err_orphan, exp_orphan);
    if (!Rst_n) begin
      check_value("rst_gnt", g, 2'b00);
      check_value("rst_mem_read", mem_read, 1'b0);
      check_value("rst_valid", v, 2'b00);
      exp_q.delete();
      exp_orphan = 1'b0;
    end else begin
      if (chk_gnt) begin
        check_value("gnt", g, exp_gnt);
        check_value("mem_read", mem_read, |exp_gnt);
        if (|exp_gnt) check_value("mem_address", mem_address, rd_addr[exp_gnt[1]]);
      end
      had_out = (exp_q.size() > 0);
      if (rv && had_out) begin
        check_value("rv_steer", v, exp_q[0].who ? 2'b10 : 2'b01);
        check_value("rv_data", rd_data[exp_q[0].who], exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check_value("rv_quiet", v, 2'b00);
      end
      if (rv && !had_out) exp_orphan = 1'b1;
      if (mem_read) begin
        exp_q.push_back('{who: g[1], data: mk_flit(mem_address)});
        mem_q.push_back('{addr: mem_address, due: cyc + LAT});
      end
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n          = 0;
    rd_req[0]  = 1'b0;
    rd_req[1]  = 1'b0;
    rd_lock[0] = 1'b0;
    rd_lock[1] = 1'b0;
    mem_stall  = 1'b0;
    chk_gnt    = 1'b1;
    exp_gnt    = 2'b00;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check_value("drain_timeout", 1, 0);
  endtask

  task automatic check_stats(input string tag, input int s0, input int s1);
    check_value({tag, "_stats0"}, stats_gnt[0], 32'(s0));
    check_value({tag, "_stats1"}, stats_gnt[1], 32'(s1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rd_req        = '{1'b1, 1'b1};
    rd_lock       = '{1'b0, 1'b0};
    rd_addr       = '{12'h010, 12'h020};
    mem_readvalid = 1'b0;
    mem_readdata  = '0;
    Rst_n         = 1'b0;
    @(posedge Clk);
    #1;
    repeat (2) cycle();

    Rst_n   = 1'b1;
    rd_req  = '{1'b0, 1'b0};
    chk_gnt = 1'b1;
    exp_gnt = 2'b00;
    cycle();
    check_stats("reset", 0, 0);

    // Round robin with both requesting, returns overlapping new issues.
    rd_req = '{1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      rd_addr[0] = 12'h010 + 12'(k);
      rd_addr[1] = 12'h020 + 12'(k);
      exp_gnt    = (k % 2 == 0) ? 2'b01 : 2'b10;
      cycle();
    end
    drain();
    check_stats("rr", 3, 3);

    // Locked 4-beat burst by requester 0 while 1 keeps asking.
    rd_req = '{1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      rd_lock[0] = (k < 3);
      rd_addr[0] = 12'h100 + 12'(k);
      rd_addr[1] = 12'h180 + 12'(k);
      exp_gnt    = (k < 4) ? 2'b01 : 2'b10;
      cycle();
    end
    drain();
    check_stats("burst", 7, 4);

    // Fill the order FIFO with the memory stalled, then free one slot.
    mem_stall = 1'b1;
    rd_req    = '{1'b1, 1'b0};
    for (int k = 0; k < MAX_OUTST; k++) begin
      rd_addr[0] = 12'h200 + 12'(k);
      exp_gnt    = 2'b01;
      cycle();
    end
    exp_gnt = 2'b00;
    repeat (3) cycle();
    allow_one  = 1'b1;
    rd_addr[0] = 12'h2F0;
    exp_gnt    = 2'b01;
    cycle();
    exp_gnt = 2'b00;
    cycle();
    drain();
    check_stats("full", 24, 4);

    // Return with nothing outstanding.
    inject_orphan = 1'b1;
    exp_gnt       = 2'b00;
    cycle();
    repeat (3) cycle();
    check_value("orphan_sticky", err_orphan, 1'b1);

    // Reset in the middle of a locked burst by requester 1.
    mem_stall  = 1'b1;
    rd_req     = '{1'b1, 1'b1};
    rd_lock    = '{1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      rd_addr[1] = 12'h300 + 12'(k);
      exp_gnt    = 2'b10;
      cycle();
    end
    Rst_n = 1'b0;
    cycle();
    Rst_n   = 1'b1;
    rd_req  = '{1'b0, 1'b0};
    rd_lock = '{1'b0, 1'b0};
    exp_gnt = 2'b00;
    cycle();
    check_stats("post_rst", 0, 0);
    drain();
    check_value("stale_orphan", err_orphan, 1'b1);
    rd_req  = '{1'b1, 1'b1};
    exp_gnt = 2'b01;
    cycle();
    exp_gnt = 2'b10;
    cycle();
    drain();
    check_stats("final", 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
